// File: rtl/stack_ram_pkg.sv
// stack_ram shared definitions: op codes, sweep FSM states, defaults.
// Optional fault flag is enabled by defining STACK_RAM_FAULT_EN.
package stack_ram_pkg;

  localparam int MEMORY_ADDR_BITS  = 3;
  localparam int MEMORY_DATA_WIDTH = 4;

  localparam logic [2:0] MEMORY_MODE_NONE  = 3'd0;
  localparam logic [2:0] MEMORY_MODE_READ  = 3'd1;
  localparam logic [2:0] MEMORY_MODE_WRITE = 3'd2;
  localparam logic [2:0] MEMORY_MODE_CLEAR = 3'd3;

  typedef enum logic [2:0] {
    STACK_RAM_OP_NONE  = 3'd0,
    STACK_RAM_OP_READ  = 3'd1,
    STACK_RAM_OP_WRITE = 3'd2,
    STACK_RAM_OP_CLEAR = 3'd3,
    STACK_RAM_OP_PUSH  = 3'd4,
    STACK_RAM_OP_POP   = 3'd5,
    STACK_RAM_OP_PEEK  = 3'd6,
    STACK_RAM_OP_RSVD  = 3'd7
  } stack_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/stack_ram_cells.sv
// stack_ram storage: one write port, one registered read port.
// Cell contents are never reset; only the read register is.
module stack_ram_cells
  import stack_ram_pkg::*;
#(
  parameter int DATA_WIDTH = MEMORY_DATA_WIDTH,
  parameter int ADDR_BITS  = MEMORY_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)       rd_data <= '0;
    else if (rclr) rd_data <= '0;
    else if (re)   rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stack_ram.sv
// stack_ram: random-access + stack memory with clear sweep FSM.
// Macro STACK_RAM_FAULT_EN enables the sticky overflow/underflow flag.
module stack_ram
  import stack_ram_pkg::*;
#(
  parameter int DATA_WIDTH = MEMORY_DATA_WIDTH,
  parameter int ADDR_BITS  = MEMORY_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            op,
  input  logic [ADDR_BITS-1:0]  address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic [ADDR_BITS:0]    sp,
  output logic                  full,
  output logic                  empty,
  output logic                  error
);

  localparam logic [ADDR_BITS:0]   DEPTH_C  = (ADDR_BITS+1)'(2 ** ADDR_BITS);
  localparam logic [ADDR_BITS:0]   SP_ONE   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] IDX_ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] IDX_LAST = {ADDR_BITS{1'b1}};

  sweep_state_e state, state_n;
  logic [ADDR_BITS-1:0] idx;
  stack_op_e op_e;
  logic idle;
  logic do_read, do_write, do_clear;
  logic do_push, do_pop, do_peek;
  logic rd_en;
  logic [ADDR_BITS-1:0] sp_lo, rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic we;

  assign op_e  = stack_op_e'(op);
  assign idle  = (state == ST_IDLE);
  assign sp_lo = sp[ADDR_BITS-1:0];
  assign full  = (sp == DEPTH_C);
  assign empty = (sp == '0);

  // Ops only count while idle; stack ops that would fault are dropped.
  assign do_read  = idle && (op_e == STACK_RAM_OP_READ);
  assign do_write = idle && (op_e == STACK_RAM_OP_WRITE);
  assign do_clear = idle && (op_e == STACK_RAM_OP_CLEAR);
  assign do_push  = idle && (op_e == STACK_RAM_OP_PUSH) && !full;
  assign do_pop   = idle && (op_e == STACK_RAM_OP_POP)  && !empty;
  assign do_peek  = idle && (op_e == STACK_RAM_OP_PEEK) && !empty;

  assign rd_en   = do_read || do_pop || do_peek;
  assign rd_addr = do_read ? address : (sp_lo - IDX_ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (do_clear) state_n = ST_SWEEP;
      ST_SWEEP: if (idx == IDX_LAST) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    we      = 1'b0;
    wr_addr = address;
    wr_data = data_in;
    unique case (state)
      ST_SWEEP: begin
        busy    = 1'b1;
        we      = !rst;
        wr_addr = idx;
        wr_data = '0;
      end
      default: begin
        we      = !rst && (do_write || do_push);
        wr_addr = do_push ? sp_lo : address;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                   idx <= '0;
    else if (state == ST_IDLE) idx <= '0;
    else                       idx <= idx + IDX_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)           sp <= '0;
    else if (do_clear) sp <= '0;
    else if (do_push)  sp <= sp + SP_ONE;
    else if (do_pop)   sp <= sp - SP_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) data_valid <= 1'b0;
    else     data_valid <= rd_en;
  end

`ifdef STACK_RAM_FAULT_EN
  logic drop;
  logic err_q;

  assign drop = idle && (((op_e == STACK_RAM_OP_PUSH) && full) ||
                (((op_e == STACK_RAM_OP_POP) ||
                  (op_e == STACK_RAM_OP_PEEK)) && empty));

  always_ff @(posedge clk) begin
    if (rst)           err_q <= 1'b0;
    else if (do_clear) err_q <= 1'b0;
    else if (drop)     err_q <= 1'b1;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  stack_ram_cells #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_cells (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .re     (rd_en),
    .rclr   (do_clear),
    .rd_addr(rd_addr),
    .rd_data(data_out)
  );

endmodule

// File: tb/tb_stack_ram.sv
// Self-checking bench for stack_ram: directed plan plus random ops
// compared against an array/counter reference model.
module tb_stack_ram;

  localparam int DW    = 4;
  localparam int AB    = 3;
  localparam int DEPTH = 8;
`ifdef STACK_RAM_FAULT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    op;
  logic [AB-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic [AB:0]   sp;
  logic          full;
  logic          empty;
  logic          error;

  always #5 clk = ~clk;

  stack_ram #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .error     (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int      m_mem [DEPTH];
  int      m_sp;
  int      m_dout;
  bit      m_valid;
  bit      m_err;
  int      m_left;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out",   32'(data_out),   32'(m_dout));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("sp",         32'(sp),         32'(m_sp));
    chk("full",       32'(full),       32'(m_sp == DEPTH));
    chk("empty",      32'(empty),      32'(m_sp == 0));
    chk("busy",       32'(busy),       32'(m_left > 0));
    chk("error",      32'(error),      32'(m_err));
  endtask

  // Reference behaviour of one clock edge given the sampled op.
  task automatic model(input int o, input int a, input int d);
    m_valid = 1'b0;
    if (m_left > 0) begin
      m_mem[DEPTH - m_left] = 0;
      m_left--;
    end else begin
      case (o)
        1: begin m_dout = m_mem[a]; m_valid = 1'b1; end
        2: m_mem[a] = d;
        3: begin m_dout = 0; m_sp = 0; m_err = 1'b0; m_left = DEPTH; end
        4: if (m_sp == DEPTH) m_err = m_err | FAULT;
           else begin m_mem[m_sp] = d; m_sp++; end
        5: if (m_sp == 0) m_err = m_err | FAULT;
           else begin m_sp--; m_dout = m_mem[m_sp]; m_valid = 1'b1; end
        6: if (m_sp == 0) m_err = m_err | FAULT;
           else begin m_dout = m_mem[m_sp-1]; m_valid = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input int o, input int a, input int d);
    @(negedge clk);
    rst     = 1'b0;
    op      = 3'(o);
    address = AB'(a);
    data_in = DW'(d);
    @(posedge clk);
    model(o, a, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    op      = 3'd4;
    address = '0;
    data_in = 4'hF;
    @(posedge clk);
    m_sp = 0; m_dout = 0; m_valid = 1'b0; m_err = 1'b0; m_left = 0;
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; op = '0; address = '0; data_in = '0;
    m_sp = 0; m_dout = 0; m_valid = 0; m_err = 0; m_left = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

    do_reset();
    do_reset();
    chk("reset_sp", 32'(sp), 32'd0);
    chk("reset_dout", 32'(data_out), 32'd0);

    for (int i = 0; i < DEPTH; i++) step(2, i, $urandom_range(15));

    // push 3,7,9 then pop them back
    step(4, 0, 3); step(4, 0, 7); step(4, 0, 9);
    chk("sp_after_3_push", 32'(sp), 32'd3);
    step(5, 0, 0);
    chk("pop1", 32'(data_out), 32'd9);
    chk("pop1_valid", 32'(data_valid), 32'd1);
    step(5, 0, 0);
    chk("pop2", 32'(data_out), 32'd7);
    step(5, 0, 0);
    chk("pop3", 32'(data_out), 32'd3);
    step(0, 0, 0);
    chk("valid_one_cycle", 32'(data_valid), 32'd0);
    chk("empty_after_pops", 32'(empty), 32'd1);

    // overflow
    for (int i = 0; i < DEPTH; i++) step(4, 0, i + 8);
    step(4, 0, 5);
    chk("full", 32'(full), 32'd1);
    chk("sp_full", 32'(sp), 32'(DEPTH));
    chk("err_overflow", 32'(error), 32'(FAULT));
    step(6, 0, 0);
    chk("top_unchanged", 32'(data_out), 32'd15);

    // underflow then clear
    step(3, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0);
    step(5, 0, 0);
    chk("underflow_valid", 32'(data_valid), 32'd0);
    chk("underflow_sp", 32'(sp), 32'd0);
    chk("err_underflow", 32'(error), 32'(FAULT));
    step(3, 0, 0);
    chk("err_cleared", 32'(error), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0);

    // write/read and peek aliasing
    step(2, 2, 4'hA);
    step(1, 2, 0);
    chk("read_back", 32'(data_out), 32'hA);
    step(4, 0, 1); step(4, 0, 2); step(4, 0, 3);
    step(2, 2, 4'hA);
    step(6, 0, 0);
    chk("peek_alias", 32'(data_out), 32'hA);

    // full clear with PUSH ignored while busy
    for (int i = 0; i < DEPTH; i++) step(2, i, i + 1);
    step(3, 0, 0);
    chk("busy_start", 32'(busy), 32'd1);
    step(4, 0, 6);
    for (int i = 1; i < DEPTH; i++) step(4, 0, 6);
    chk("busy_done", 32'(busy), 32'd0);
    chk("sp_after_clear", 32'(sp), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, i, 0);
      chk("cleared_cell", 32'(data_out), 32'd0);
    end

    // reset mid-sweep
    for (int i = 0; i < DEPTH; i++) step(2, i, i + 1);
    step(3, 0, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    do_reset();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sp", 32'(sp), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1, i, 0);
    step(1, 2, 0);
    chk("abort_cell2", 32'(data_out), 32'd0);
    step(1, 5, 0);
    chk("abort_cell5", 32'(data_out), 32'd6);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      int o;
      o = int'($urandom_range(7));
      if (o == 3 && $urandom_range(3) != 0) o = 4;
      if (n % 97 == 50) do_reset();
      else step(o, $urandom_range(DEPTH - 1), $urandom_range(15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ram.md
# stack_ram

Parametrised data memory for the stack calculator. Successor to the fixed 4-bit cell array: configurable width and depth, a built-in stack pointer with push/pop/peek, full and empty flags, and a multi-cycle hardware clear sweep. It sits between the instruction decoder and the ALU operand path. It serves both random-access and stack-style accesses to the same storage.

## Interface
Parameters:
- `DATA_WIDTH`, 4: bits per cell.
- `ADDR_BITS`, 3: address width; `DEPTH = 2**ADDR_BITS` cells.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 3: operation code, sampled every cycle while `busy` is low.
- `address` in `ADDR_BITS`: cell index for READ and WRITE.
- `data_in` in `DATA_WIDTH`: write and push data.
- `data_out` out `DATA_WIDTH`: registered read result; holds its value between reads.
- `data_valid` out 1: one-cycle pulse when `data_out` was loaded by READ, POP or PEEK.
- `busy` out 1: clear sweep in progress.
- `sp` out `ADDR_BITS+1`: current stack entry count, 0..DEPTH.
- `full` out 1: `sp == DEPTH`.
- `empty` out 1: `sp == 0`.
- `error` out 1: sticky stack fault flag; tied 0 unless `STACK_RAM_FAULT_EN` is defined.

## Operation
Op codes 0–3 keep the existing memory-mode values:
- NONE 0: no state change.
- READ 1: `data_out <= mem[address]`.
- WRITE 2: `mem[address] <= data_in`; `sp` is unchanged.
- CLEAR 3: `data_out <= 0`; `sp <= 0`; clears `error`; starts the clear sweep.
- PUSH 4: `mem[sp] <= data_in`; `sp <= sp+1`.
- POP 5: `data_out <= mem[sp-1]`; `sp <= sp-1`.
- PEEK 6: `data_out <= mem[sp-1]`; `sp` is unchanged.
- 7: reserved, treated as NONE.

Stack and flag rules:
- The stack grows from cell 0 upward. Random READ and WRITE may alias stack cells. This is legal and not flagged.
- PUSH when `full`, and POP or PEEK when `empty`, are dropped. No memory, `sp` or `data_out` change, and no `data_valid` pulse.
- `full` and `empty` are combinational from `sp`.

Clear-sweep FSM:
- States: IDLE, SWEEP.
- IDLE→SWEEP on an accepted CLEAR. The index counter starts at 0.
- In SWEEP: write 0 to `mem[idx]` and increment `idx` each cycle.
- After writing cell DEPTH-1, return to IDLE.
- `busy` is high for exactly DEPTH cycles, in the SWEEP state.
- While `busy`, every `op` (including CLEAR) is ignored, not queued.

Reset:
- Output values: `data_out=0`, `data_valid=0`, `busy=0`, `sp=0`, `error=0`; FSM returns to IDLE.
- Cell contents are not reset.
- Reset asserted mid-sweep aborts the sweep and leaves cells partially cleared.
- `rst` dominates any `op` in the same cycle.

## Timing
- All ops take effect on the posedge at which they are sampled.
- `data_out` and `data_valid` are valid in the cycle after READ, POP or PEEK is sampled.
- Written data can be read back by a READ or PEEK sampled on the next cycle. There is no same-cycle bypass.
- `sp`, `full` and `empty` update one cycle after PUSH or POP.
- Back-to-back PUSH and POP on consecutive cycles sustain one op per cycle.
- A CLEAR sampled at cycle N has these effects:
  - `busy` is high for cycles N+1..N+DEPTH.
  - The first non-ignored op is sampled at cycle N+DEPTH+1.
- Throughput is one op per cycle outside a sweep.

## Configuration
- `STACK_RAM_FAULT_EN` defined:
  - A dropped PUSH (overflow) or dropped POP/PEEK (underflow) sets `error` on the next cycle.
  - `error` holds until `rst` or an accepted CLEAR.
  - If a fault and a CLEAR coincide, CLEAR wins and `error` is 0.
- Not defined:
  - `error` is constant 0 and no fault logic is synthesised.
  - Drop behaviour is identical to the defined case.

## Structure
- `constants.v`:
  - Add `STACK_RAM_OP_*` codes (3-bit) alongside the existing `MEMORY_MODE_*`.
  - Add default `MEMORY_ADDR_BITS` and data-width constants used as parameter defaults.
- One sub-module `stack_ram_cells`:
  - Plain synchronous storage with one write port and one registered read port.
  - The top level multiplexes the write port between the decoder and the clear sweep.
- The FSM, stack pointer and fault logic live in `stack_ram`.

## Test plan
- Reset, then PUSH 3, 7, 9 → `sp` = 3. POP ×3 → `data_out` 9, 7, 3, each with a one-cycle `data_valid`; then `empty` = 1.
- PUSH DEPTH values, then one more PUSH 5 → `full` = 1, `sp` = DEPTH, top cell unchanged. With the macro defined, `error` = 1 next cycle.
- POP on an empty stack → no `data_valid`, `sp` = 0. `error` = 1 only with the macro; a subsequent CLEAR returns it to 0.
- WRITE 0xA to address 2, then READ address 2 next cycle → `data_out` = 0xA one cycle later. PEEK with `sp` = 3 returns `mem[2]` = 0xA.
- Fill memory, CLEAR → `busy` is high for DEPTH cycles and a PUSH issued during `busy` is ignored. Afterwards, READ of every address returns 0 and `sp` = 0.
- Assert `rst` during cycle 3 of a sweep → next cycle `busy` = 0 and `sp` = 0. Cells 0..2 are 0 and cell 5 retains its pre-clear value.
